// File: rtl/mc_seq_ctrl_if.sv
// Memory handshake bundle between the sequencer (master) and the
// instruction/data memory subsystem (slave).
interface mc_seq_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/mc_seq_ctrl.sv
// Handshake-aware multi-cycle sequencer for the RV32I core family.
// Owns the PC and instruction latch, stalls on memory acks with a
// bounded wait, and flags halt (all-zero instruction) and traps.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; pc retained between single steps
// IF    | fetch request at pc, wait for imem_ack (bounded)
// ID    | one-cycle decode strobe; zero instruction halts
// EX    | one-cycle execute strobe
// MEM   | data access (bounded wait) or one idle cycle if no mem_op
// WB    | one-cycle writeback strobe; pc <= pc_next, retire
// HALT  | absorbing, halted=1
// TRAP  | absorbing, trap=1 with trap_cause
module mc_seq_ctrl #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] START_ADDR = '0,
    parameter int unsigned     TIMEOUT    = 15,
    parameter bit              SKIP_MEM   = 1'b1,
    parameter int unsigned     CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    mc_seq_ctrl_if.master    bus,
    output logic [XLEN-1:0]  inst,
    output logic [XLEN-1:0]  pc,
    output logic             id_en,
    output logic             ex_en,
    output logic             wb_en,
    input  logic             mem_op,
    input  logic             is_store,
    input  logic [XLEN-1:0]  dmem_addr,
    input  logic [XLEN-1:0]  pc_next,
    output logic             halted,
    output logic             trap,
    output logic [2:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_TRAP = 3'd7
    } state_t;

    // The wait counter holds the number of ack-less cycles already spent;
    // the trap fires on the cycle that would make it reach TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    localparam logic [2:0] CAUSE_IMEM_TO   = 3'd1;
    localparam logic [2:0] CAUSE_DMEM_ALGN = 3'd2;
    localparam logic [2:0] CAUSE_DMEM_TO   = 3'd3;
    localparam logic [2:0] CAUSE_PC_ALGN   = 3'd4;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_inst;
    logic             r_halted;
    logic             r_trap;
    logic [2:0]       r_cause;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_instret;

    logic             w_imem_req;
    logic             w_dmem_req;
    logic             w_dmem_we;
    logic             w_id_en;
    logic             w_ex_en;
    logic             w_wb_en;
    logic             w_wait_inc;
    logic             w_latch_inst;
    logic             w_pc_load;
    logic             w_set_halt;
    logic             w_set_trap;
    logic [2:0]       w_cause;
    logic             w_dmem_misalign;
    logic             w_pc_misalign;
    logic             w_active;

    assign w_dmem_misalign = (dmem_addr[1:0] != 2'b00);
    assign w_pc_misalign   = (pc_next[1:0] != 2'b00);
    assign w_active        = (r_state == S_IF) || (r_state == S_ID) || (r_state == S_EX) ||
                             (r_state == S_MEM) || (r_state == S_WB);

    // State register and ack wait counter; the counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    // Next-state decode and combinational request/strobe outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_imem_req   = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_id_en      = 1'b0;
        w_ex_en      = 1'b0;
        w_wb_en      = 1'b0;
        w_wait_inc   = 1'b0;
        w_latch_inst = 1'b0;
        w_pc_load    = 1'b0;
        w_set_halt   = 1'b0;
        w_set_trap   = 1'b0;
        w_cause      = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_IF;
            end
            S_IF: begin
                w_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_latch_inst = 1'b1;
                    w_state_nxt  = S_ID;
                end else if (r_wait == WAIT_LAST) begin
                    w_set_trap  = 1'b1;
                    w_cause     = CAUSE_IMEM_TO;
                    w_state_nxt = S_TRAP;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_ID: begin
                w_id_en = 1'b1;
                if (r_inst == '0) begin
                    w_set_halt  = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_EX;
                end
            end
            S_EX: begin
                w_ex_en = 1'b1;
                if (mem_op || !SKIP_MEM) w_state_nxt = S_MEM;
                else                     w_state_nxt = S_WB;
            end
            S_MEM: begin
                if (!mem_op) begin
                    w_state_nxt = S_WB;
                end else if (w_dmem_misalign) begin
                    w_set_trap  = 1'b1;
                    w_cause     = CAUSE_DMEM_ALGN;
                    w_state_nxt = S_TRAP;
                end else begin
                    w_dmem_req = 1'b1;
                    w_dmem_we  = is_store;
                    if (bus.dmem_ack) begin
                        w_state_nxt = S_WB;
                    end else if (r_wait == WAIT_LAST) begin
                        w_set_trap  = 1'b1;
                        w_cause     = CAUSE_DMEM_TO;
                        w_state_nxt = S_TRAP;
                    end else begin
                        w_wait_inc = 1'b1;
                    end
                end
            end
            S_WB: begin
                w_wb_en = 1'b1;
                if (w_pc_misalign) begin
                    w_set_trap  = 1'b1;
                    w_cause     = CAUSE_PC_ALGN;
                    w_state_nxt = S_TRAP;
                end else begin
                    w_pc_load   = 1'b1;
                    w_state_nxt = step_mode ? S_IDLE : S_IF;
                end
            end
            S_HALT, S_TRAP: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // PC and instruction latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= START_ADDR;
            r_inst <= '0;
        end else begin
            if (w_latch_inst) r_inst <= bus.imem_rdata;
            if (w_pc_load)    r_pc   <= pc_next;
        end
    end

    // Sticky halt/trap flags; cause is written only on the entry edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
            r_trap   <= 1'b0;
            r_cause  <= 3'd0;
        end else begin
            if (w_set_halt) r_halted <= 1'b1;
            if (w_set_trap) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    // Free-wrapping performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            if (w_active)  r_cycle   <= r_cycle + 1'b1;
            if (w_pc_load) r_instret <= r_instret + 1'b1;
        end
    end

    assign bus.imem_req  = w_imem_req;
    assign bus.imem_addr = r_pc;
    assign bus.dmem_req  = w_dmem_req;
    assign bus.dmem_we   = w_dmem_we;
    assign inst          = r_inst;
    assign pc            = r_pc;
    assign id_en         = w_id_en;
    assign ex_en         = w_ex_en;
    assign wb_en         = w_wb_en;
    assign halted        = r_halted;
    assign trap          = r_trap;
    assign trap_cause    = r_cause;
    assign cycle_cnt     = r_cycle;
    assign instret_cnt   = r_instret;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Scoreboard bench for mc_seq_ctrl: a reference model turns each planned
// instruction into expected events (WB, HALT, TRAP); a monitor pops and
// compares them as the DUT raises wb_en / halted / trap.
module tb_mc_seq_ctrl;
    localparam int          XLEN    = 32;
    localparam int          TIMEOUT = 15;
    localparam int          CNT_W   = 32;
    localparam bit          SKIP    = 1'b1;
    localparam logic [31:0] START   = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              step_mode = 1'b0;
    logic [XLEN-1:0]   inst, pc;
    logic              id_en, ex_en, wb_en;
    logic              mem_op = 1'b0;
    logic              is_store = 1'b0;
    logic [XLEN-1:0]   dmem_addr = '0;
    logic [XLEN-1:0]   pc_next = '0;
    logic              halted, trap;
    logic [2:0]        trap_cause;
    logic [CNT_W-1:0]  cycle_cnt, instret_cnt;
    bit                force_iack = 1'b0;

    mc_seq_ctrl_if #(.XLEN(XLEN)) bus ();

    mc_seq_ctrl #(
        .XLEN(XLEN), .START_ADDR(START), .TIMEOUT(TIMEOUT), .SKIP_MEM(SKIP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .bus(bus),
        .inst(inst), .pc(pc), .id_en(id_en), .ex_en(ex_en), .wb_en(wb_en),
        .mem_op(mem_op), .is_store(is_store), .dmem_addr(dmem_addr), .pc_next(pc_next),
        .halted(halted), .trap(trap), .trap_cause(trap_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          i_dly;
        logic        mop;
        logic        st;
        logic [31:0] daddr;
        int          d_dly;
        logic [31:0] pcn;
        bit          stray;
    } item_t;

    typedef enum int {K_WB = 0, K_HALT = 1, K_TRAP = 2} kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] pc;
        logic [31:0] word;
        int          cyc;
        int          ret;
        int          icyc;
        int          dcyc;
        int          wcyc;
        int          cause;
    } exp_t;

    item_t plan[$];
    exp_t  expq[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic [31:0] m_pc = START;
    int    m_cyc = 0;
    int    m_ret = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic item_t mk(input logic [31:0] word, input int i_dly, input logic mop,
                                 input logic st, input logic [31:0] daddr, input int d_dly,
                                 input logic [31:0] pcn, input bit stray);
        item_t it;
        it.word = word; it.i_dly = i_dly; it.mop = mop; it.st = st;
        it.daddr = daddr; it.d_dly = d_dly; it.pcn = pcn; it.stray = stray;
        return it;
    endfunction

    function automatic exp_t mk_exp(input kind_t k, input logic [31:0] word, input int icyc,
                                    input int dcyc, input int wcyc, input int cause);
        exp_t e;
        e.kind = k; e.pc = m_pc; e.word = word; e.cyc = m_cyc; e.ret = m_ret;
        e.icyc = icyc; e.dcyc = dcyc; e.wcyc = wcyc; e.cause = cause;
        return e;
    endfunction

    // Reference model: cycle accounting per stage, straight from the stage rules.
    task automatic issue(input item_t it);
        int icyc, dcyc;
        plan.push_back(it);
        if (it.i_dly >= TIMEOUT) begin
            m_cyc += TIMEOUT;
            expq.push_back(mk_exp(K_TRAP, 0, TIMEOUT, 0, 0, 1));
            return;
        end
        icyc = it.i_dly + 1;
        m_cyc += icyc + 1;
        if (it.word == 0) begin
            expq.push_back(mk_exp(K_HALT, 0, icyc, 0, 0, 0));
            return;
        end
        m_cyc += 1;
        dcyc = 0;
        if (it.mop) begin
            if (it.daddr[1:0] != 2'b00) begin
                m_cyc += 1;
                expq.push_back(mk_exp(K_TRAP, it.word, icyc, 0, 0, 2));
                return;
            end
            if (it.d_dly >= TIMEOUT) begin
                m_cyc += TIMEOUT;
                expq.push_back(mk_exp(K_TRAP, it.word, icyc, TIMEOUT, it.st ? TIMEOUT : 0, 3));
                return;
            end
            dcyc = it.d_dly + 1;
            m_cyc += dcyc;
        end else if (!SKIP) begin
            m_cyc += 1;
        end
        expq.push_back(mk_exp(K_WB, it.word, icyc, dcyc, it.st && it.mop ? dcyc : 0, 0));
        m_cyc += 1;
        if (it.pcn[1:0] != 2'b00) begin
            expq.push_back(mk_exp(K_TRAP, it.word, 0, 0, 0, 4));
        end else begin
            m_pc = it.pcn;
            m_ret += 1;
        end
    endtask

    task automatic score(input kind_t k, input int icnt, input int dcnt, input int wcnt);
        exp_t e;
        if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected event: got kind %0d, expected none", k);
            return;
        end
        e = expq.pop_front();
        chk("event kind", 64'(k), 64'(e.kind));
        chk("pc", 64'(pc), 64'(e.pc));
        if (k != K_TRAP) chk("inst", 64'(inst), 64'(e.word));
        chk("cycle_cnt", 64'(cycle_cnt), 64'(e.cyc));
        chk("instret_cnt", 64'(instret_cnt), 64'(e.ret));
        chk("imem_req cycles", 64'(icnt), 64'(e.icyc));
        chk("dmem_req cycles", 64'(dcnt), 64'(e.dcyc));
        chk("dmem_we cycles", 64'(wcnt), 64'(e.wcyc));
        if (k == K_TRAP) chk("trap_cause", 64'(trap_cause), 64'(e.cause));
    endtask

    task automatic monitor();
        int   icnt = 0, dcnt = 0, wcnt = 0;
        logic prev_trap = 1'b0, prev_halt = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                icnt = 0; dcnt = 0; wcnt = 0;
                prev_trap = 1'b0; prev_halt = 1'b0;
            end else begin
                if (bus.imem_req) icnt++;
                if (bus.dmem_req) begin
                    dcnt++;
                    if (bus.dmem_we) wcnt++;
                end
                if (wb_en) begin
                    score(K_WB, icnt, dcnt, wcnt);
                    icnt = 0; dcnt = 0; wcnt = 0;
                end
                if (trap && !prev_trap) begin
                    score(K_TRAP, icnt, dcnt, wcnt);
                    icnt = 0; dcnt = 0; wcnt = 0;
                end
                if (halted && !prev_halt) begin
                    score(K_HALT, icnt, dcnt, wcnt);
                    icnt = 0; dcnt = 0; wcnt = 0;
                end
                prev_trap = trap;
                prev_halt = halted;
            end
        end
    endtask

    // Memory/decoder responder: acks after the planned delay, garbage rdata while waiting.
    task automatic responder();
        item_t cur;
        bit    need = 1'b1;
        int    ic = 0, dc = 0;
        cur = mk(32'h1, 0, 1'b0, 1'b0, 32'h0, 0, 32'h4, 1'b0);
        forever begin
            @(negedge clk);
            if (rst) begin
                need = 1'b1; ic = 0; dc = 0;
                bus.imem_ack = bus.imem_req;
                bus.dmem_ack = bus.dmem_req;
                continue;
            end
            if (need && plan.size() > 0) begin
                cur = plan.pop_front();
                need = 1'b0;
            end
            mem_op = cur.mop; is_store = cur.st; dmem_addr = cur.daddr; pc_next = cur.pcn;
            if (bus.imem_req) begin
                ic++;
                bus.imem_ack   = (ic == cur.i_dly + 1);
                bus.imem_rdata = bus.imem_ack ? cur.word : $urandom;
            end else begin
                ic = 0;
                bus.imem_ack   = force_iack;
                bus.imem_rdata = $urandom;
            end
            if (bus.dmem_req) begin
                dc++;
                bus.dmem_ack = (dc == cur.d_dly + 1);
            end else begin
                dc = 0;
                bus.dmem_ack = bus.imem_req && cur.stray;
            end
            if (wb_en) need = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; force_iack = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        if (expq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover events: got %0d outstanding, expected 0", expq.size());
            expq.delete();
        end
        plan.delete();
        m_pc = START; m_cyc = 0; m_ret = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain timeout: got %0d events outstanding, expected 0", expq.size());
            expq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " pc"}, 64'(pc), 64'(m_pc));
        chk({tag, " instret"}, 64'(instret_cnt), 64'(m_ret));
        chk({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(m_cyc));
        chk({tag, " imem_req"}, 64'(bus.imem_req), 64'(0));
    endtask

    task automatic run_step(input item_t it, input string tag);
        step_mode = 1'b1;
        issue(it);
        pulse_start();
        drain(200);
        chk_idle(tag);
    endtask

    task automatic run_term(input item_t it);
        step_mode = 1'b0;
        issue(it);
        pulse_start();
        drain(200);
    endtask

    task automatic gen_item(output item_t it);
        int r;
        r = $urandom_range(0, 9);
        it.i_dly = (r < 6) ? $urandom_range(0, 2) : (r < 9) ? $urandom_range(3, TIMEOUT - 2) : TIMEOUT - 1;
        r = $urandom_range(0, 9);
        it.d_dly = (r < 6) ? $urandom_range(0, 2) : (r < 9) ? $urandom_range(3, TIMEOUT - 2) : TIMEOUT - 1;
        it.word  = $urandom | 32'h1;
        it.mop   = ($urandom_range(0, 1) == 1);
        it.st    = it.mop && ($urandom_range(0, 1) == 1);
        it.daddr = $urandom & 32'hFFFF_FFFC;
        it.pcn   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
        it.stray = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        item_t it;
        fork
            monitor();
            responder();
            begin
                #(10 * 60000);
                $display("FAIL watchdog: simulation exceeded its time limit");
                $fatal(1, "watchdog");
            end
        join_none

        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = '0;

        do_reset();
        @(negedge clk);
        chk("rst pc", 64'(pc), 64'(START));
        chk("rst inst", 64'(inst), 64'(0));
        chk("rst imem_req", 64'(bus.imem_req), 64'(0));
        chk("rst dmem_req", 64'(bus.dmem_req), 64'(0));
        chk("rst strobes", 64'({id_en, ex_en, wb_en}), 64'(0));
        chk("rst flags", 64'({halted, trap, trap_cause}), 64'(0));
        chk("rst cycle_cnt", 64'(cycle_cnt), 64'(0));
        chk("rst instret", 64'(instret_cnt), 64'(0));

        // ADDI, immediate ack: 4 active cycles, pc=4, one retire.
        run_step(mk(32'h0010_0093, 0, 1'b0, 1'b0, 32'h0, 0, 32'h4, 1'b0), "addi");
        chk("addi pc", 64'(pc), 64'h4);
        chk("addi cycle_cnt", 64'(cycle_cnt), 64'd4);
        // LW with delayed acks, then an aligned SW, then both ack boundaries.
        run_step(mk(32'h0000_2083, 3, 1'b1, 1'b0, 32'h100, 2, m_pc + 4, 1'b0), "lw");
        run_step(mk(32'h0010_2223, 1, 1'b1, 1'b1, 32'h104, 4, m_pc + 4, 1'b1), "sw");
        run_step(mk(32'h0000_2083, TIMEOUT - 1, 1'b1, 1'b0, 32'h108, TIMEOUT - 1, m_pc + 4, 1'b1), "edge");

        // Back-to-back random instructions, ended by an all-zero word.
        do_reset();
        step_mode = 1'b0;
        for (int i = 0; i < 40; i++) begin
            gen_item(it);
            issue(it);
        end
        issue(mk(32'h0, $urandom_range(0, 3), 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0));
        @(posedge clk); #2 start = 1'b1;
        drain(4000);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("halt frozen cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
        chk("halt instret", 64'(instret_cnt), 64'(m_ret));
        chk("halt no wb_en", 64'(wb_en), 64'(0));

        // Instruction fetch timeout; a late ack must not revive the core.
        do_reset();
        run_term(mk(32'h0010_0093, TIMEOUT, 1'b0, 1'b0, 32'h0, 0, 32'h4, 1'b0));
        @(posedge clk); #2 force_iack = 1'b1;
        repeat (3) @(negedge clk);
        force_iack = 1'b0;
        chk("to1 trap", 64'(trap), 64'(1));
        chk("to1 cause", 64'(trap_cause), 64'(1));
        chk("to1 imem_req", 64'(bus.imem_req), 64'(0));
        chk("to1 inst", 64'(inst), 64'(0));
        chk("to1 cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));

        do_reset();
        run_term(mk(32'h0010_2023, 0, 1'b1, 1'b1, 32'h102, 0, 32'h4, 1'b0));
        chk("algn dmem_req", 64'(bus.dmem_req), 64'(0));
        do_reset();
        run_term(mk(32'h0000_2083, 2, 1'b1, 1'b0, 32'h200, TIMEOUT, 32'h4, 1'b0));
        chk("to3 dmem_req", 64'(bus.dmem_req), 64'(0));
        do_reset();
        run_term(mk(32'h0010_0093, 0, 1'b0, 1'b0, 32'h0, 0, 32'h6, 1'b0));
        chk("pcalgn pc", 64'(pc), 64'(START));
        chk("pcalgn instret", 64'(instret_cnt), 64'(0));

        // Single-step over two ADDIs, then reset in the middle of a data wait.
        do_reset();
        run_step(mk(32'h0010_0093, 0, 1'b0, 1'b0, 32'h0, 0, 32'h4, 1'b0), "step1");
        chk("step1 pc", 64'(pc), 64'h4);
        run_step(mk(32'h0010_0093, 0, 1'b0, 1'b0, 32'h0, 0, 32'h8, 1'b0), "step2");
        chk("step2 pc", 64'(pc), 64'h8);
        plan.push_back(mk(32'h0000_2083, 0, 1'b1, 1'b0, 32'h200, 10, 32'hC, 1'b0));
        pulse_start();
        begin
            int n = 0;
            while (!bus.dmem_req && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("rst-mid dmem_req seen", 64'(bus.dmem_req), 64'(1));
        end
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst-mid dmem_req", 64'(bus.dmem_req), 64'(0));
        chk("rst-mid pc", 64'(pc), 64'(START));
        chk("rst-mid inst", 64'(inst), 64'(0));
        chk("rst-mid cycle_cnt", 64'(cycle_cnt), 64'(0));
        @(posedge clk); #2 rst = 1'b0;
        plan.delete();
        m_pc = START; m_cyc = 0; m_ret = 0;
        repeat (3) @(negedge clk);
        chk_idle("post-rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
